// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared constants, TMDS mode encodings and scheduler state
//               type for the HDMI data-island packet path.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

  // Data-island phase lengths in pixel clocks
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;
  localparam int COOLDOWN_LEN = 4;

  // TMDS channel mode encodings
  localparam logic [2:0] MODE_CONTROL      = 3'd0;
  localparam logic [2:0] MODE_ISLAND_DATA  = 3'd3;
  localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

  // Cycles needed after the deciding cycle to open an island with one packet
  // (preamble + lead guard + packet + trail guard) and to append one more
  // packet at the end of the current one (packet + trail guard).
  localparam logic [11:0] c_island_min_budget = 12'(PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN);
  localparam logic [11:0] c_packet_min_budget = 12'(PACKET_LEN + GUARD_LEN);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PREAMBLE    = 3'd1,
    ST_LEAD_GUARD  = 3'd2,
    ST_PACKET      = 3'd3,
    ST_TRAIL_GUARD = 3'd4,
    ST_COOLDOWN    = 3'd5
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search starts at the
//               source after `pointer` and wraps modulo N; output is one-hot
//               or all-zero when nothing requests.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Scan sources pointer+1 .. pointer+N (mod N) and take the first requester
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = PTR_W'((int'(pointer) + i) % N);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : packet_scheduler
// Description : Schedules HDMI data islands into blanking windows. Tracks the
//               remaining window budget, sequences preamble / guard / packet /
//               cooldown phases and grants packet slots round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_scheduler
  import hdmi_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int MAX_PACKETS = 18
) (
  input  logic                   clk_pixel,
  input  logic                   reset_n,
  input  logic                   blank_start,
  input  logic [11:0]            blank_length,
  input  logic [NUM_SOURCES-1:0] req,
  output logic [NUM_SOURCES-1:0] grant,
  output logic [2:0]             mode,
  output logic                   preamble,
  output logic [4:0]             packet_index,
  output logic                   busy
);

  localparam int PTR_W = $clog2(NUM_SOURCES);

  sched_state_t           r_state;
  sched_state_t           w_state_next;
  logic [2:0]             r_phase;
  logic [2:0]             w_phase_next;
  logic [11:0]            r_rem;
  logic [11:0]            w_rem_eff;
  logic [11:0]            w_rem_next;
  logic [4:0]             r_pkt_count;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_grant_idx;
  logic [NUM_SOURCES-1:0] w_arb_grant;
  logic                   w_more_packets;
  logic                   w_pkt_start;
  logic                   w_last_char;
  logic [2:0]             w_mode_next;
  logic [4:0]             w_index_next;
  logic [NUM_SOURCES-1:0] w_grant_next;

  rr_arbiter #(
    .N     (NUM_SOURCES),
    .PTR_W (PTR_W)
  ) u_arbiter (
    .req     (req),
    .pointer (r_ptr),
    .grant   (w_arb_grant)
  );

  // Window budget: r_rem is the number of cycles left after the current one.
  // On blank_start (honoured only in IDLE) the current-cycle value is
  // blank_length-1, so the register picks up one less on the next cycle.
  always_comb begin
    w_rem_eff = r_rem;
    if (r_state == ST_IDLE && blank_start) begin
      w_rem_eff = (blank_length == 12'd0) ? 12'd0 : blank_length - 12'd1;
    end
    w_rem_next = (w_rem_eff == 12'd0) ? 12'd0 : w_rem_eff - 12'd1;
  end

  // Encode the arbiter's one-hot grant back into a pointer value
  always_comb begin
    w_grant_idx = r_ptr;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_arb_grant[i]) begin
        w_grant_idx = PTR_W'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decision and next values of the registered outputs
  always_comb begin
    w_state_next   = r_state;
    w_last_char    = (packet_index == 5'(PACKET_LEN - 1));
    w_more_packets = (|req) && (r_pkt_count < 5'(MAX_PACKETS)) &&
                     (r_rem >= c_packet_min_budget);
    case (r_state)
      ST_IDLE: begin
        if ((|req) && (w_rem_eff >= c_island_min_budget)) begin
          w_state_next = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (r_phase == 3'(PREAMBLE_LEN - 1)) w_state_next = ST_LEAD_GUARD;
      end
      ST_LEAD_GUARD: begin
        if (r_phase == 3'(GUARD_LEN - 1)) w_state_next = ST_PACKET;
      end
      ST_PACKET: begin
        if (w_last_char) begin
          w_state_next = w_more_packets ? ST_PACKET : ST_TRAIL_GUARD;
        end
      end
      ST_TRAIL_GUARD: begin
        if (r_phase == 3'(GUARD_LEN - 1)) w_state_next = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (r_phase == 3'(COOLDOWN_LEN - 1)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    // A packet starts when entering PACKET or re-entering it after index 31
    w_pkt_start  = (w_state_next == ST_PACKET) &&
                   ((r_state != ST_PACKET) || w_last_char);
    w_phase_next = (w_state_next == r_state) ? r_phase + 3'd1 : 3'd0;
    w_index_next = (w_state_next == ST_PACKET && !w_pkt_start) ?
                   packet_index + 5'd1 : 5'd0;
    w_grant_next = w_pkt_start ? w_arb_grant : '0;

    case (w_state_next)
      ST_LEAD_GUARD, ST_TRAIL_GUARD: w_mode_next = MODE_ISLAND_GUARD;
      ST_PACKET:                     w_mode_next = MODE_ISLAND_DATA;
      default:                       w_mode_next = MODE_CONTROL;
    endcase
  end

  // Registered outputs, phase counter, budget, packet count and RR pointer
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= '0;
      mode         <= MODE_CONTROL;
      preamble     <= 1'b0;
      packet_index <= 5'd0;
      busy         <= 1'b0;
      r_phase      <= 3'd0;
      r_rem        <= 12'd0;
      r_pkt_count  <= 5'd0;
      r_ptr        <= PTR_W'(NUM_SOURCES - 1);
    end else begin
      grant        <= w_grant_next;
      mode         <= w_mode_next;
      preamble     <= (w_state_next == ST_PREAMBLE);
      packet_index <= w_index_next;
      busy         <= (w_state_next != ST_IDLE);
      r_phase      <= w_phase_next;
      r_rem        <= w_rem_next;
      if (r_state == ST_IDLE && w_state_next == ST_PREAMBLE) begin
        r_pkt_count <= 5'd0;
      end else if (w_pkt_start) begin
        r_pkt_count <= r_pkt_count + 5'd1;
      end
      // A null packet (no requester left) leaves the pointer where it was
      if (w_pkt_start && (|w_arb_grant)) begin
        r_ptr <= w_grant_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_scheduler
// Description : Directed, table-driven bench for packet_scheduler. A second
//               instance with MAX_PACKETS=2 covers the per-island packet cap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_scheduler;

  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b0;
  logic        blank_start = 1'b0;
  logic [11:0] blank_length = 12'd0;
  logic [3:0]  req = 4'd0;

  logic [3:0]  grant,  grant2;
  logic [2:0]  mode,   mode2;
  logic        preamble, preamble2;
  logic [4:0]  packet_index, packet_index2;
  logic        busy,   busy2;

  int n_vec  = 0;
  int n_miss = 0;

  packet_scheduler #(.NUM_SOURCES(4), .MAX_PACKETS(18)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .blank_start(blank_start),
    .blank_length(blank_length), .req(req), .grant(grant), .mode(mode),
    .preamble(preamble), .packet_index(packet_index), .busy(busy)
  );

  packet_scheduler #(.NUM_SOURCES(4), .MAX_PACKETS(2)) dut2 (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .blank_start(blank_start),
    .blank_length(blank_length), .req(req), .grant(grant2), .mode(mode2),
    .preamble(preamble2), .packet_index(packet_index2), .busy(busy2)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int          sc;
    int          t;
    logic        bs;
    logic [11:0] bl;
    logic [3:0]  rq;
    logic        busy;
    logic        pre;
    logic [2:0]  mode;
    logic [3:0]  gnt;
    logic [4:0]  idx;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int sc, int t, logic bs, int bl, logic [3:0] rq,
                              logic b, logic p, logic [2:0] m, logic [3:0] g, int idx);
    vec_t e;
    e.sc = sc; e.t = t; e.bs = bs; e.bl = 12'(bl); e.rq = rq;
    e.busy = b; e.pre = p; e.mode = m; e.gnt = g; e.idx = 5'(idx);
    tbl.push_back(e);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    blank_start = 1'b0;
    req = 4'd0;
    #1;
    chk("reset outputs dut",  {busy, preamble, mode, grant, packet_index}, 32'd0);
    chk("reset outputs dut2", {busy2, preamble2, mode2, grant2, packet_index2}, 32'd0);
    repeat (2) @(posedge clk_pixel);
    #1 reset_n = 1'b1;
  endtask

  // Cycle t of a scenario: inputs applied 1 time unit after the opening edge,
  // outputs compared on the falling edge of the same cycle.
  task automatic run_sc(int sc, int tmax, bit use2);
    int   ids[$];
    int   k;
    bit   hit;
    vec_t e;
    logic [13:0] got;
    logic [13:0] exp;
    foreach (tbl[i]) if (tbl[i].sc == sc) ids.push_back(i);
    k = 0;
    for (int t = 0; t <= tmax; t++) begin
      @(posedge clk_pixel);
      #1;
      blank_start = 1'b0;
      hit = 1'b0;
      if (k < ids.size() && tbl[ids[k]].t == t) begin
        e = tbl[ids[k]];
        blank_start  = e.bs;
        blank_length = e.bl;
        req          = e.rq;
        hit          = 1'b1;
      end
      @(negedge clk_pixel);
      if (hit) begin
        got = use2 ? {busy2, preamble2, mode2, grant2, packet_index2}
                   : {busy, preamble, mode, grant, packet_index};
        exp = {e.busy, e.pre, e.mode, e.gnt, e.idx};
        n_vec++;
        if (got !== exp) begin
          n_miss++;
          $display("FAIL sc%0d t%0d: got busy=%b pre=%b mode=%0d grant=%b idx=%0d, expected busy=%b pre=%b mode=%0d grant=%b idx=%0d",
                   sc, t, got[13], got[12], got[11:9], got[8:5], got[4:0],
                   exp[13], exp[12], exp[11:9], exp[8:5], exp[4:0]);
        end
        k++;
      end
    end
    blank_start = 1'b0;
    req = 4'd0;
  endtask

  initial begin : main
    bit found;

    // sc1: single packet, blank_length=160
    add(1,  0, 1, 160, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(1,  1, 0, 160, 4'b0001, 1, 1, 0, 4'b0000, 0);
    add(1,  8, 0, 160, 4'b0001, 1, 1, 0, 4'b0000, 0);
    add(1,  9, 0, 160, 4'b0001, 1, 0, 4, 4'b0000, 0);
    add(1, 10, 0, 160, 4'b0001, 1, 0, 4, 4'b0000, 0);
    add(1, 11, 0, 160, 4'b0001, 1, 0, 3, 4'b0001, 0);
    add(1, 12, 0, 160, 4'b0000, 1, 0, 3, 4'b0000, 1);
    add(1, 42, 0, 160, 4'b0000, 1, 0, 3, 4'b0000, 31);
    add(1, 43, 0, 160, 4'b0000, 1, 0, 4, 4'b0000, 0);
    add(1, 44, 0, 160, 4'b0000, 1, 0, 4, 4'b0000, 0);
    add(1, 45, 0, 160, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add(1, 48, 0, 160, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add(1, 49, 0, 160, 4'b0000, 0, 0, 0, 4'b0000, 0);
    // sc2: window of 44 is one short
    add(2,  0, 1,  44, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(2,  1, 0,  44, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(2,  4, 0,  44, 4'b0001, 0, 0, 0, 4'b0000, 0);
    // sc3: window of 45 just fits
    add(3,  0, 1,  45, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(3,  1, 0,  45, 4'b0001, 1, 1, 0, 4'b0000, 0);
    add(3, 11, 0,  45, 4'b0001, 1, 0, 3, 4'b0001, 0);
    add(3, 12, 0,  45, 4'b0000, 1, 0, 3, 4'b0000, 1);
    add(3, 43, 0,  45, 4'b0000, 1, 0, 4, 4'b0000, 0);
    add(3, 49, 0,  45, 4'b0000, 0, 0, 0, 4'b0000, 0);
    // sc4: all four request, round-robin across five packets
    add(4,   0, 1, 400, 4'b1111, 0, 0, 0, 4'b0000, 0);
    add(4,  11, 0, 400, 4'b1111, 1, 0, 3, 4'b0001, 0);
    add(4,  12, 0, 400, 4'b1111, 1, 0, 3, 4'b0000, 1);
    add(4,  43, 0, 400, 4'b1111, 1, 0, 3, 4'b0010, 0);
    add(4,  75, 0, 400, 4'b1111, 1, 0, 3, 4'b0100, 0);
    add(4, 107, 0, 400, 4'b1111, 1, 0, 3, 4'b1000, 0);
    add(4, 139, 0, 400, 4'b1111, 1, 0, 3, 4'b0001, 0);
    add(4, 140, 0, 400, 4'b0000, 1, 0, 3, 4'b0000, 1);
    add(4, 171, 0, 400, 4'b0000, 1, 0, 4, 4'b0000, 0);
    add(4, 177, 0, 400, 4'b0000, 0, 0, 0, 4'b0000, 0);
    // sc5: MAX_PACKETS=2 instance, continuous request
    add(5,  0, 1, 400, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(5, 11, 0, 400, 4'b0001, 1, 0, 3, 4'b0001, 0);
    add(5, 43, 0, 400, 4'b0001, 1, 0, 3, 4'b0001, 0);
    add(5, 74, 0, 400, 4'b0001, 1, 0, 3, 4'b0000, 31);
    add(5, 75, 0, 400, 4'b0001, 1, 0, 4, 4'b0000, 0);
    add(5, 77, 0, 400, 4'b0001, 1, 0, 0, 4'b0000, 0);
    add(5, 80, 0, 400, 4'b0001, 1, 0, 0, 4'b0000, 0);
    add(5, 81, 0, 400, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(5, 82, 0, 400, 4'b0001, 1, 1, 0, 4'b0000, 0);
    // sc6: rem=34 at index 31 -> second packet
    add(6,  0, 1,  77, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(6, 42, 0,  77, 4'b0001, 1, 0, 3, 4'b0000, 31);
    add(6, 43, 0,  77, 4'b0001, 1, 0, 3, 4'b0001, 0);
    add(6, 75, 0,  77, 4'b0001, 1, 0, 4, 4'b0000, 0);
    add(6, 81, 0,  77, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(6, 83, 0,  77, 4'b0001, 0, 0, 0, 4'b0000, 0);
    // sc7: rem=33 at index 31 -> trail guard
    add(7,  0, 1,  76, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(7, 42, 0,  76, 4'b0001, 1, 0, 3, 4'b0000, 31);
    add(7, 43, 0,  76, 4'b0001, 1, 0, 4, 4'b0000, 0);
    add(7, 49, 0,  76, 4'b0001, 0, 0, 0, 4'b0000, 0);
    add(7, 52, 0,  76, 4'b0001, 0, 0, 0, 4'b0000, 0);
    // sc8: request withdrawn before the slot -> null packet
    add(8,  0, 1, 160, 4'b0010, 0, 0, 0, 4'b0000, 0);
    add(8,  1, 0, 160, 4'b0000, 1, 1, 0, 4'b0000, 0);
    add(8, 10, 0, 160, 4'b0000, 1, 0, 4, 4'b0000, 0);
    add(8, 11, 0, 160, 4'b0000, 1, 0, 3, 4'b0000, 0);
    add(8, 43, 0, 160, 4'b0000, 1, 0, 4, 4'b0000, 0);

    do_reset(); run_sc(1, 50, 1'b0);
    do_reset(); run_sc(2, 5, 1'b0);
    do_reset(); run_sc(3, 50, 1'b0);
    do_reset(); run_sc(4, 178, 1'b0);
    do_reset(); run_sc(5, 82, 1'b1);
    do_reset(); run_sc(6, 83, 1'b0);
    do_reset(); run_sc(7, 52, 1'b0);
    do_reset(); run_sc(8, 44, 1'b0);

    // Reset in the middle of a packet, then recovery
    do_reset();
    @(posedge clk_pixel);
    #1;
    blank_start = 1'b1; blank_length = 12'd160; req = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clk_pixel);
      #1;
      blank_start = 1'b0;
      if (packet_index == 5'd1) req = 4'b0000;
      if (mode == 3'd3 && packet_index == 5'd10) found = 1'b1;
    end
    chk("reach packet index 10", {31'd0, found}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async reset mid packet", {busy, preamble, mode, grant, packet_index}, 32'd0);
    @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
    req = 4'b0001;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    chk("no island without blank_start", {31'd0, busy}, 32'd0);
    @(posedge clk_pixel);
    #1 blank_start = 1'b1;
    @(posedge clk_pixel);
    #1 blank_start = 1'b0;
    @(negedge clk_pixel);
    chk("post-reset preamble", {30'd0, busy, preamble}, 32'd3);
    repeat (10) @(posedge clk_pixel);
    @(negedge clk_pixel);
    chk("post-reset grant", {25'd0, mode, grant}, {25'd0, 3'd3, 4'b0001});
    req = 4'b0000;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
